// File: rtl/wash_tank_timer.sv
// Washer tank model: tracks water level, wash/spin timers and a fill watchdog,
// and reports the current phase and a sticky fault to the washer controller.
module wash_tank_timer #(
  parameter int unsigned FULL_LEVEL   = 8,
  parameter int unsigned CYCLE_TICKS  = 16,
  parameter int unsigned SPIN_TICKS   = 12,
  parameter int unsigned FILL_TIMEOUT = 32,
  parameter int unsigned LEVEL_W      = 4,
  parameter int unsigned TMR_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fillvalve_on,
  input  logic               drainvalve_on,
  input  logic               motor_on,
  input  logic               spin_on,
  input  logic               supply_ok,
  output logic               filled,
  output logic               drained,
  output logic               cycletime_out,
  output logic               spintime_out,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         phase,
  output logic               fault
);

  localparam logic [LEVEL_W-1:0] FULL_L   = LEVEL_W'(FULL_LEVEL);
  localparam logic [TMR_W-1:0]   CYC_MAX  = TMR_W'(CYCLE_TICKS);
  localparam logic [TMR_W-1:0]   SPIN_MAX = TMR_W'(SPIN_TICKS);
  localparam logic [TMR_W-1:0]   WDOG_MAX = TMR_W'(FILL_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    DRAIN = 3'd3,
    SPIN  = 3'd4,
    FAULT = 3'd7
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] wdog;
  logic [TMR_W-1:0] cyc_cnt;
  logic [TMR_W-1:0] spin_cnt;

  logic             lvl_inc;
  logic             lvl_dec;
  logic [TMR_W-1:0] wdog_nxt;
  logic             fault_cond;

  // Level movement, watchdog look-ahead and fault detection for this edge
  always_comb begin
    lvl_inc    = 1'b0;
    lvl_dec    = 1'b0;
    wdog_nxt   = '0;
    fault_cond = 1'b0;
    lvl_inc    = fillvalve_on && !drainvalve_on && supply_ok && (level < FULL_L);
    lvl_dec    = drainvalve_on && !fillvalve_on && (level != '0);
    if (fillvalve_on && !lvl_inc) begin
      wdog_nxt = wdog + TMR_W'(1);
    end
    // Fault fires on the edge the watchdog would reach its limit
    fault_cond = (fillvalve_on && drainvalve_on) || (wdog_nxt >= WDOG_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      level    <= '0;
      wdog     <= '0;
      cyc_cnt  <= '0;
      spin_cnt <= '0;
    end else if (state != FAULT) begin
      if (lvl_inc) begin
        level <= level + LEVEL_W'(1);
      end else if (lvl_dec) begin
        level <= level - LEVEL_W'(1);
      end

      wdog <= wdog_nxt;

      if (!motor_on) begin
        cyc_cnt <= '0;
      end else if (cyc_cnt < CYC_MAX) begin
        cyc_cnt <= cyc_cnt + TMR_W'(1);
      end

      if (!spin_on) begin
        spin_cnt <= '0;
      end else if (spin_cnt < SPIN_MAX) begin
        spin_cnt <= spin_cnt + TMR_W'(1);
      end

      if (fault_cond) begin
        state <= FAULT;
      end else if (fillvalve_on) begin
        state <= FILL;
      end else if (spin_on) begin
        state <= SPIN;
      end else if (drainvalve_on) begin
        state <= DRAIN;
      end else if (motor_on) begin
        state <= WASH;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Status flags decode registered state only
  assign filled        = (level == FULL_L);
  assign drained       = (level == '0);
  assign cycletime_out = (state != FAULT) && (cyc_cnt == CYC_MAX);
  assign spintime_out  = (state != FAULT) && (spin_cnt == SPIN_MAX);
  assign fault         = (state == FAULT);
  assign phase         = state;

endmodule

// File: tb/tb_wash_tank_timer.sv
// Bench for wash_tank_timer: directed scenarios plus random traffic checked
// against an arithmetic model of the tank, timers and fault rules.
module tb_wash_tank_timer;

  localparam int FULL = 8;
  localparam int CT   = 16;
  localparam int ST   = 12;
  localparam int FT   = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fillvalve_on = 1'b0, drainvalve_on = 1'b0, motor_on = 1'b0;
  logic       spin_on = 1'b0, supply_ok = 1'b0;
  logic       filled, drained, cycletime_out, spintime_out, fault;
  logic [3:0] level;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int m_level, m_wd, m_cyc, m_spin, m_phase;
  bit m_fault;

  wash_tank_timer #(
    .FULL_LEVEL(FULL), .CYCLE_TICKS(CT), .SPIN_TICKS(ST),
    .FILL_TIMEOUT(FT), .LEVEL_W(4), .TMR_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .fillvalve_on(fillvalve_on), .drainvalve_on(drainvalve_on),
    .motor_on(motor_on), .spin_on(spin_on), .supply_ok(supply_ok),
    .filled(filled), .drained(drained),
    .cycletime_out(cycletime_out), .spintime_out(spintime_out),
    .level(level), .phase(phase), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit f, input bit d, input bit m, input bit s,
                            input bit sup, input bit r);
    bit gain, loss, trip;
    int wd_next;
    if (r) begin
      m_level = 0; m_wd = 0; m_cyc = 0; m_spin = 0; m_phase = 0; m_fault = 0;
    end else if (!m_fault) begin
      gain    = f && !d && sup && (m_level < FULL);
      loss    = d && !f && (m_level > 0);
      wd_next = (f && !gain) ? m_wd + 1 : 0;
      trip    = (f && d) || (wd_next >= FT);
      m_level = m_level + int'(gain) - int'(loss);
      m_wd    = wd_next;
      m_cyc   = m ? ((m_cyc + 1 > CT) ? CT : m_cyc + 1) : 0;
      m_spin  = s ? ((m_spin + 1 > ST) ? ST : m_spin + 1) : 0;
      if (trip)   m_phase = 7;
      else if (f) m_phase = 1;
      else if (s) m_phase = 4;
      else if (d) m_phase = 3;
      else if (m) m_phase = 2;
      else        m_phase = 0;
      m_fault = trip;
    end
  endtask

  // Drive one edge's inputs, clock it, advance the model, sample after the edge
  task automatic step(input bit f, input bit d, input bit m, input bit s,
                      input bit sup, input bit r);
    fillvalve_on = f; drainvalve_on = d; motor_on = m; spin_on = s;
    supply_ok = sup; rst = r;
    @(posedge clk);
    model_edge(f, d, m, s, sup, r);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({filled, drained, cycletime_out, spintime_out, fault, phase, level} !== 12'b0100_0000_0000) begin
      n_fail++;
      $display("FAIL reset_values: got f=%b d=%b ct=%b st=%b flt=%b ph=%0d lvl=%0d expected 0 1 0 0 0 0 0",
               filled, drained, cycletime_out, spintime_out, fault, phase, level);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 0, 1, 0);
      n_checks++;
      if (level !== 4'(i) || phase !== 3'd1 || drained !== 1'b0 || filled !== (i == 8)) begin
        n_fail++;
        $display("FAIL fill edge %0d: got lvl=%0d ph=%0d drained=%b filled=%b expected lvl=%0d ph=1 drained=0 filled=%b",
                 i, level, phase, drained, filled, i, (i == 8));
      end
    end
  endtask

  task automatic test_fill_saturation();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (level !== 4'd8 || fault !== 1'b0 || filled !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_saturation: got lvl=%0d fault=%b filled=%b expected 8 0 1", level, fault, filled);
    end
  endtask

  task automatic test_wash();
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 1, 0, 1, 0);
      n_checks++;
      if (cycletime_out !== (i >= CT) || phase !== 3'd2) begin
        n_fail++;
        $display("FAIL wash edge %0d: got ct=%b ph=%0d expected ct=%b ph=2", i, cycletime_out, phase, (i >= CT));
      end
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    n_checks++;
    if (cycletime_out !== 1'b0 || level !== 4'd8) begin
      n_fail++;
      $display("FAIL wash_clear: got ct=%b lvl=%0d expected ct=0 lvl=8", cycletime_out, level);
    end
  endtask

  task automatic test_drain_spin();
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0, 1, 0);
      n_checks++;
      if (level !== 4'(8 - i) || drained !== (i == 8) || phase !== 3'd3) begin
        n_fail++;
        $display("FAIL drain edge %0d: got lvl=%0d drained=%b ph=%0d expected lvl=%0d drained=%b ph=3",
                 i, level, drained, phase, 8 - i, (i == 8));
      end
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0);
    n_checks++;
    if (level !== 4'd0 || drained !== 1'b1 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_saturation: got lvl=%0d drained=%b fault=%b expected 0 1 0", level, drained, fault);
    end
    for (int i = 1; i <= 14; i++) begin
      step(0, 0, 0, 1, 1, 0);
      n_checks++;
      if (spintime_out !== (i >= ST) || phase !== 3'd4) begin
        n_fail++;
        $display("FAIL spin edge %0d: got st=%b ph=%0d expected st=%b ph=4", i, spintime_out, phase, (i >= ST));
      end
    end
  endtask

  task automatic test_fill_timeout();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
    for (int i = 1; i <= FT; i++) begin
      step(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (fault !== (i == FT) || level !== 4'd3) begin
        n_fail++;
        $display("FAIL fill_timeout edge %0d: got fault=%b lvl=%0d expected fault=%b lvl=3", i, fault, level, (i == FT));
      end
    end
    n_checks++;
    if (phase !== 3'd7) begin
      n_fail++;
      $display("FAIL timeout_phase: got %0d expected 7", phase);
    end
    for (int i = 0; i < 10; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    n_checks++;
    if (phase !== 3'd7 || fault !== 1'b1 || level !== 4'd3 || cycletime_out !== 1'b0 || spintime_out !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_absorbing: got ph=%0d fault=%b lvl=%0d ct=%b st=%b expected 7 1 3 0 0",
               phase, fault, level, cycletime_out, spintime_out);
    end
  endtask

  task automatic test_overlap();
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    n_checks++;
    if (fault !== 1'b1 || phase !== 3'd7 || level !== 4'd2) begin
      n_fail++;
      $display("FAIL overlap: got fault=%b ph=%0d lvl=%0d expected 1 7 2", fault, phase, level);
    end
    step(0, 1, 0, 0, 1, 0);
    n_checks++;
    if (level !== 4'd2) begin
      n_fail++;
      $display("FAIL overlap_frozen: got lvl=%0d expected 2", level);
    end
    step(1, 1, 1, 1, 1, 1);
    n_checks++;
    if ({filled, drained, cycletime_out, spintime_out, fault, phase, level} !== 12'b0100_0000_0000) begin
      n_fail++;
      $display("FAIL reset_from_fault: got f=%b d=%b ct=%b st=%b flt=%b ph=%0d lvl=%0d expected 0 1 0 0 0 0 0",
               filled, drained, cycletime_out, spintime_out, fault, phase, level);
    end
  endtask

  task automatic test_random();
    logic [11:0] got, exp;
    int r;
    bit f, d;
    step(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      f = (r < 40) || (r == 99);
      d = (r >= 60);
      step(f, d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 149) == 0));
      got = {filled, drained, cycletime_out, spintime_out, fault, phase, level};
      exp = {m_level == FULL, m_level == 0, !m_fault && (m_cyc == CT), !m_fault && (m_spin == ST),
             m_fault, 3'(m_phase), 4'(m_level)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b expected %b ({filled,drained,ct,st,fault,phase,level})", n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_fill_saturation();
    test_wash();
    test_drain_spin();
    test_fill_timeout();
    test_overlap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_tank_timer.md
WASH_TANK_TIMER -- requirements
Module: wash_tank_timer

Interface
REQ-001 Parameter FULL_LEVEL, default 8: tank level count at which the tank is full.
REQ-002 Parameter CYCLE_TICKS, default 16: motor-on clock cycles per wash cycle.
REQ-003 Parameter SPIN_TICKS, default 12: spin-on clock cycles per spin.
REQ-004 Parameter FILL_TIMEOUT, default 32: maximum fill cycles without level gain before fault.
REQ-005 Parameter LEVEL_W, default 4; TMR_W, default 8: level and timer register widths.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 fillvalve_on  input  1  fill valve open, driven by the washer controller.
REQ-009 drainvalve_on  input  1  drain valve open, driven by the washer controller.
REQ-010 motor_on  input  1  wash motor running.
REQ-011 spin_on  input  1  spin phase active.
REQ-012 supply_ok  input  1  inlet water pressure present; level rises only when high.
REQ-013 filled  output  1  level equals FULL_LEVEL; feeds controller filled.
REQ-014 drained  output  1  level equals 0; feeds controller drained.
REQ-015 cycletime_out  output  1  wash cycle time elapsed.
REQ-016 spintime_out  output  1  spin time elapsed.
REQ-017 level  output  LEVEL_W  current tank level count.
REQ-018 phase  output  3  FSM state encoding.
REQ-019 fault  output  1  sticky fault flag.

Function
REQ-020 FSM states SHALL be IDLE=0, FILL=1, WASH=2, DRAIN=3, SPIN=4, FAULT=7; phase SHALL equal the state register.
REQ-021 Next state, evaluated each edge in priority order: fault condition -> FAULT; fillvalve_on -> FILL; spin_on -> SPIN; drainvalve_on -> DRAIN; motor_on -> WASH; otherwise IDLE.
REQ-022 FAULT SHALL be absorbing; only rst leaves it.
REQ-023 Fault condition SHALL be fillvalve_on and drainvalve_on both high on one edge, or the fill watchdog reaching FILL_TIMEOUT.
REQ-024 Level SHALL increment by 1 on an edge with fillvalve_on=1, drainvalve_on=0, supply_ok=1, and level<FULL_LEVEL; it saturates at FULL_LEVEL.
REQ-025 Level SHALL decrement by 1 on an edge with drainvalve_on=1, fillvalve_on=0, and level>0; it saturates at 0.
REQ-026 Level SHALL hold in all other cases, including FAULT.
REQ-027 filled and drained SHALL be decoded from the level register only, with no combinational path from inputs, so they are valid the cycle after the level update.
REQ-028 The fill watchdog SHALL increment on each edge where fillvalve_on=1 and level did not increment. It SHALL clear on any edge where fillvalve_on=0 or level increments.
REQ-029 The cycle counter SHALL increment on each edge with motor_on=1 while below CYCLE_TICKS, and SHALL clear on any edge with motor_on=0.
REQ-030 cycletime_out SHALL equal (cycle counter == CYCLE_TICKS).
REQ-031 The spin counter SHALL follow the same rules as the cycle counter, using spin_on and SPIN_TICKS; spintime_out SHALL equal (spin counter == SPIN_TICKS).
REQ-032 In FAULT, all counters SHALL freeze, cycletime_out=0, spintime_out=0, and fault=1.
REQ-033 Timer counters SHALL never wrap; the TMR_W bits SHALL hold CYCLE_TICKS, SPIN_TICKS and FILL_TIMEOUT.

Reset
REQ-034 With rst=1 at an edge: level=0, all counters=0, phase=IDLE, fault=0, filled=0, drained=1, cycletime_out=0, spintime_out=0.
REQ-035 Reset SHALL take priority over all inputs and SHALL apply mid-operation, including from FAULT.

Verification
REQ-036 Fill: supply_ok=1, fillvalve_on=1 for 8 edges from reset -> level 1..8, filled=1 after the 8th edge, phase=FILL, drained=0 after the 1st edge.
REQ-037 Wash timing: motor_on=1 held -> cycletime_out=1 after the 16th edge and stays 1; motor_on=0 for one edge -> cycletime_out=0, counter=0.
REQ-038 Drain/spin: from level 8, drainvalve_on=1 for 8 edges -> drained=1. Then spin_on=1 -> phase=SPIN, spintime_out=1 after the 12th edge.
REQ-039 Fill timeout: fillvalve_on=1, supply_ok=0 for 32 edges -> fault=1, phase=7, level unchanged; then inputs toggled -> still FAULT.
REQ-040 Overlap: fillvalve_on=drainvalve_on=1 on one edge -> fault=1 next cycle, level frozen; rst=1 one edge -> all REQ-034 values.
REQ-041 Saturation: fill held 4 extra edges at level 8 -> level stays 8 with no fault; drain held at level 0 -> level stays 0.
